decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, 16, register/operand/immediate width; SHALL be >= 16.
REQ-002 Parameter WB_BYPASS, 1, 1 = same-cycle writeback forwarded to reads.
REQ-003 Parameter LU_STALL, 1, 1 = load-use interlock enabled.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  fetch presents instruction.
REQ-007 in_ready  out  1  stage accepts instruction this cycle.
REQ-008 instr  in  16  instruction word: opcode [15:11], Rs [10:8], Rt [7:5], funct [1:0].
REQ-009 wb_en / wb_sel / wb_data  in  1 / 3 / DATA_W  register-file write port from MEM/WB.
REQ-010 flush  in  1  discard the instruction held in the output register.
REQ-011 out_valid  out  1  decoded instruction available.
REQ-012 out_ready  in  1  execute stage accepts.
REQ-013 out_a / out_b / out_imm  out  DATA_W each  Rs value, Rt value, selected extended immediate.
REQ-014 out_ctrl  out  ctrl_t  decoded control bundle (package type).
REQ-015 out_dest  out  3  destination register.
REQ-016 halt / err  out  1 / 1  sticky HALT-seen / sticky illegal-opcode flags.

Function
REQ-017 Stage SHALL contain an 8 x DATA_W register file, 2 read ports (Rs, Rt), 1 write port; a write occurs on clk when wb_en=1.
REQ-018 With WB_BYPASS=1, a read whose select equals wb_sel while wb_en=1 SHALL return wb_data in the same cycle; with WB_BYPASS=0, it SHALL return the old value.
REQ-019 Control decode SHALL use the package function decode_ctrl(opcode, funct), giving reads_rs, reads_rt, is_load, reg_write, dest_sel, imm_sel, illegal.
REQ-020 imm_sel SHALL choose sign-extend of [4:0], [7:0] or [10:0], or zero-extend of [4:0] or [7:0], to DATA_W.
REQ-021 Output register (ID/EX) SHALL hold out_a, out_b, out_imm, out_ctrl, out_dest and out_valid; latency is exactly 1 cycle from acceptance to out_valid=1.
REQ-022 Acceptance SHALL occur when in_valid && in_ready; in_ready = !stall && (!out_valid || out_ready).
REQ-023 When out_valid && !out_ready and there is no flush, all output registers SHALL hold their values unchanged.
REQ-024 Load-use stall (LU_STALL=1) SHALL assert when out_valid, out_ctrl.is_load and out_ctrl.reg_write are all set, and the incoming instruction reads Rs or Rt equal to out_dest.
REQ-025 During a stall with out_ready=1, the register SHALL load a bubble (out_valid=0) and SHALL NOT accept instr, so the stall lasts exactly 1 cycle.
REQ-026 flush=1 SHALL clear out_valid at the next edge, overriding hold and load; in that cycle in_ready=0.
REQ-027 When in_valid=0 and the register drains, out_valid SHALL become 0; data fields may retain stale values.
REQ-028 Accepting an opcode with illegal=1 SHALL set err, which stays set until reset; the instruction passes downstream as a NOP with reg_write=0.
REQ-029 Accepting HALT (opcode 00000) SHALL set halt (sticky); afterwards in_ready=0 until reset.
REQ-030 A writeback and a read of the same register in a stall cycle SHALL still update the register file (writes are never blocked).

Reset
REQ-031 rst=0 SHALL asynchronously clear out_valid, halt, err and all register-file entries to 0.
REQ-032 On reset release, in_ready SHALL be 1 on the first edge, and out_a/out_b/out_imm/out_dest/out_ctrl SHALL read 0.
REQ-033 Reset asserted mid-stall or mid-hold SHALL discard the in-flight instruction with no partial state.

Structure
REQ-034 Package decode_pkg SHALL hold ctrl_t, imm_sel_t, opcode constants (including OP_HALT) and decode_ctrl().
REQ-035 Register file SHALL be the sub-module rf_bypass (parameters DATA_W, WB_BYPASS); everything else is inline.

Verification
REQ-036 Write R3=0x1234 via wb, then decode ADD Rs=3 -> out_a=0x1234 one cycle after acceptance.
REQ-037 wb_en=1, wb_sel=5, wb_data=0xBEEF while decoding Rs=5 -> out_a=0xBEEF (WB_BYPASS=1) or the old value (WB_BYPASS=0).
REQ-038 LD to R2, then ADD reading R2 -> one bubble (out_valid=0 for 1 cycle), then ADD valid.
REQ-039 Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0; flush on cycle 2 -> out_valid=0 next edge.
REQ-040 Illegal opcode then HALT -> err=1, halt=1, in_ready stays 0; rst=0 pulse -> all flags 0.
REQ-041 SLBI imm 0x80 -> out_imm=0x0080 (zero-extend); BEQZ imm 0x80 -> out_imm=0xFF80 (sign-extend).

Source files
------------

// File: rtl/decode_pkg.sv
// Decode stage shared types: control bundle, immediate/destination selects,
// opcode constants and the control decoder used by decode_stage.
package decode_pkg;

  typedef enum logic [2:0] {
    IMM_S5,
    IMM_S8,
    IMM_S11,
    IMM_Z5,
    IMM_Z8
  } imm_sel_t;

  typedef enum logic [1:0] {
    DST_RT,
    DST_RD,
    DST_RS,
    DST_R7
  } dest_sel_t;

  typedef struct packed {
    logic      reads_rs;
    logic      reads_rt;
    logic      is_load;
    logic      reg_write;
    dest_sel_t dest_sel;
    imm_sel_t  imm_sel;
    logic [1:0] alu_fn;
    logic      illegal;
  } ctrl_t;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_ALU   = 5'b11011;

  function automatic ctrl_t decode_ctrl(
    input logic [4:0] op,
    input logic [1:0] funct
  );
    ctrl_t c;
    c = '0;
    c.alu_fn = funct;
    unique case (1'b1)
      (op == OP_HALT),
      (op == OP_NOP): ;
      (op == OP_J): c.imm_sel = IMM_S11;
      (op == OP_JAL): begin
        c.reg_write = 1'b1;
        c.dest_sel  = DST_R7;
        c.imm_sel   = IMM_S11;
      end
      (op == OP_ADDI): begin
        c.reads_rs  = 1'b1;
        c.reg_write = 1'b1;
      end
      (op == OP_ANDNI): begin
        c.reads_rs  = 1'b1;
        c.reg_write = 1'b1;
        c.imm_sel   = IMM_Z5;
      end
      (op == OP_BEQZ): begin
        c.reads_rs = 1'b1;
        c.imm_sel  = IMM_S8;
      end
      (op == OP_ST): begin
        c.reads_rs = 1'b1;
        c.reads_rt = 1'b1;
      end
      (op == OP_LD): begin
        c.reads_rs  = 1'b1;
        c.is_load   = 1'b1;
        c.reg_write = 1'b1;
      end
      (op == OP_SLBI): begin
        c.reads_rs  = 1'b1;
        c.reg_write = 1'b1;
        c.dest_sel  = DST_RS;
        c.imm_sel   = IMM_Z8;
      end
      (op == OP_LBI): begin
        c.reg_write = 1'b1;
        c.dest_sel  = DST_RS;
        c.imm_sel   = IMM_S8;
      end
      (op == OP_ALU): begin
        c.reads_rs  = 1'b1;
        c.reads_rt  = 1'b1;
        c.reg_write = 1'b1;
        c.dest_sel  = DST_RD;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_rf.sv
// 8-entry register file, 2 read / 1 write, optional same-cycle write bypass.
// Ports: clk, rst_n, wb_en/wb_sel/wb_data write, sel_a/sel_b -> rd_a/rd_b.
module rf_bypass #(
  parameter int DATA_W    = 16,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        sel_a,
  input  logic [2:0]        sel_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] mem [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (wb_en) begin
      mem[wb_sel] <= wb_data;
    end
  end

  always_comb begin
    rd_a = mem[sel_a];
    rd_b = mem[sel_b];
    if (WB_BYPASS && wb_en && wb_sel == sel_a)
      rd_a = wb_data;
    if (WB_BYPASS && wb_en && wb_sel == sel_b)
      rd_b = wb_data;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: regfile read, control decode, immediate extend, ID/EX reg.
// Ports: fetch in_valid/in_ready/instr, wb port, flush, EX out_* handshake.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit WB_BYPASS = 1'b1,
  parameter bit LU_STALL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output ctrl_t             out_ctrl,
  output logic [2:0]        out_dest,
  output logic              halt,
  output logic              err
);

  logic [2:0]        rs, rt, rd;
  ctrl_t             dec;
  ctrl_t             dec_q;
  logic [DATA_W-1:0] a_val, b_val, imm;
  logic [2:0]        dest;
  logic              lu_hit, stall, accept;

  assign rs  = instr[10:8];
  assign rt  = instr[7:5];
  assign rd  = instr[4:2];
  assign dec = decode_ctrl(instr[15:11], instr[1:0]);

  rf_bypass #(
    .DATA_W   (DATA_W),
    .WB_BYPASS(WB_BYPASS)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst),
    .wb_en  (wb_en),
    .wb_sel (wb_sel),
    .wb_data(wb_data),
    .sel_a  (rs),
    .sel_b  (rt),
    .rd_a   (a_val),
    .rd_b   (b_val)
  );

  always_comb begin
    imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
    unique case (dec.imm_sel)
      IMM_S8:  imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      IMM_S11: imm = {{(DATA_W-11){instr[10]}}, instr[10:0]};
      IMM_Z5:  imm = {{(DATA_W-5){1'b0}}, instr[4:0]};
      IMM_Z8:  imm = {{(DATA_W-8){1'b0}}, instr[7:0]};
      default: ;
    endcase
  end

  always_comb begin
    dest = rt;
    unique case (dec.dest_sel)
      DST_RD:  dest = rd;
      DST_RS:  dest = rs;
      DST_R7:  dest = 3'd7;
      default: ;
    endcase
  end

  // Illegal opcodes travel on as a NOP that never writes back.
  always_comb begin
    dec_q = dec;
    dec_q.reg_write = dec.reg_write & ~dec.illegal;
  end

  assign lu_hit = out_valid && out_ctrl.is_load &&
                  out_ctrl.reg_write && in_valid &&
                  ((dec.reads_rs && rs == out_dest) ||
                   (dec.reads_rt && rt == out_dest));
  assign stall  = LU_STALL && lu_hit;

  assign in_ready = !stall && !flush && !halt &&
                    (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_imm   <= '0;
      out_ctrl  <= '0;
      out_dest  <= '0;
      halt      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept && dec.illegal)
        err <= 1'b1;
      if (accept && instr[15:11] == OP_HALT)
        halt <= 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
        // A stall or idle input leaves a bubble; data fields go stale.
        out_valid <= accept;
        if (accept) begin
          out_a    <= a_val;
          out_b    <= b_val;
          out_imm  <= imm;
          out_ctrl <= dec_q;
          out_dest <= dest;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected
// ID/EX contents; a negedge monitor pops and compares on each handshake.
module tb_decode_stage;
  import decode_pkg::*;

  localparam bit WB_BYPASS = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a, out_b, out_imm;
  ctrl_t       out_ctrl;
  logic [2:0]  out_dest;
  logic        halt, err;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [2:0]  dest;
    logic [2:0]  fl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int prev_pop = 0;
  int gap = 0;

  decode_stage #(
    .DATA_W   (16),
    .WB_BYPASS(WB_BYPASS),
    .LU_STALL (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .wb_en    (wb_en),
    .wb_sel   (wb_sel),
    .wb_data  (wb_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_imm  (out_imm),
    .out_ctrl (out_ctrl),
    .out_dest (out_dest),
    .halt     (halt),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [4:0] op,
                                     input logic [2:0] s,
                                     input logic [2:0] t,
                                     input logic [4:0] lo);
    return {op, s, t, lo};
  endfunction

  function automatic exp_t mk(input logic [15:0] a,
                              input logic [15:0] b,
                              input logic [15:0] imm,
                              input logic [2:0]  dest,
                              input logic [2:0]  fl);
    exp_t x;
    x.a = a; x.b = b; x.imm = imm;
    x.dest = dest; x.fl = fl;
    return x;
  endfunction

  // Monitor: one pop per consumed (non-flushed) output.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got a=%h want none", out_a);
      end else begin
        e = q.pop_front();
        chk("out_a", {16'h0, out_a}, {16'h0, e.a});
        chk("out_b", {16'h0, out_b}, {16'h0, e.b});
        chk("out_imm", {16'h0, out_imm}, {16'h0, e.imm});
        chk("out_dest", {29'h0, out_dest}, {29'h0, e.dest});
        chk("out_flags",
            {29'h0, out_ctrl.is_load, out_ctrl.reg_write,
             out_ctrl.illegal},
            {29'h0, e.fl});
        gap = cyc - prev_pop;
        prev_pop = cyc;
      end
    end
  end

  task automatic issue(input logic [15:0] ins,
                       input exp_t ex,
                       input bit push,
                       input bit wb,
                       input logic [2:0] ws,
                       input logic [15:0] wd,
                       output int waits);
    in_valid = 1'b1;
    instr = ins;
    wb_en = wb;
    wb_sel = ws;
    wb_data = wd;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    chk("accept", {31'h0, in_ready}, 32'd1);
    if (push && in_ready) q.push_back(ex);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wb_en = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b0;
    in_valid = 1'b0;
    instr = '0;
    wb_en = 1'b0;
    wb_sel = '0;
    wb_data = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_halt", {31'h0, halt}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_out_a", {16'h0, out_a}, 0);
    chk("rst_out_imm", {16'h0, out_imm}, 0);
    chk("rst_out_ctrl", {20'h0, out_ctrl}, 0);
    chk("rst_out_dest", {29'h0, out_dest}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", {31'h0, in_ready}, 1);

    // R3 = 0x1234, then ADD reading it
    wb_en = 1'b1; wb_sel = 3'd3; wb_data = 16'h1234;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    issue(rr(OP_ALU, 3'd3, 3'd0, 5'b00100),
          mk(16'h1234, 16'h0, 16'h0004, 3'd1, 3'b010),
          1, 0, 3'd0, 16'h0, w);

    // same-cycle writeback of R5 while reading it
    issue(rr(OP_ALU, 3'd5, 3'd3, 5'b01001),
          mk(WB_BYPASS ? 16'hBEEF : 16'h0000, 16'h1234,
             16'h0009, 3'd2, 3'b010),
          1, 1, 3'd5, 16'hBEEF, w);

    // load-use: LD R2 then ADD reading R2
    issue(rr(OP_LD, 3'd3, 3'd2, 5'h1F),
          mk(16'h1234, 16'h0, 16'hFFFF, 3'd2, 3'b110),
          1, 0, 3'd0, 16'h0, w);
    issue(rr(OP_ALU, 3'd2, 3'd3, 5'b10010),
          mk(16'h0, 16'h1234, 16'hFFF2, 3'd4, 3'b010),
          1, 0, 3'd0, 16'h0, w);
    chk("lu_waits", w, 1);
    @(negedge clk);
    #1;
    chk("lu_gap", gap, 2);

    // hold with out_ready=0, then flush
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(rr(OP_ADDI, 3'd3, 3'd6, 5'h05),
          mk(16'h1234, 16'h0, 16'h0005, 3'd6, 3'b010),
          0, 0, 3'd0, 16'h0, w);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, out_valid}, 1);
      chk("hold_in_ready", {31'h0, in_ready}, 0);
      chk("hold_a", {16'h0, out_a}, 32'h1234);
      chk("hold_imm", {16'h0, out_imm}, 32'h0005);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr = rr(OP_ADDI, 3'd5, 3'd7, 5'h0A);
    @(negedge clk);
    chk("flush_in_ready", {31'h0, in_ready}, 0);
    chk("flush_hold_a", {16'h0, out_a}, 32'h1234);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'h0, out_valid}, 0);
    issue(rr(OP_ADDI, 3'd5, 3'd7, 5'h0A),
          mk(16'hBEEF, 16'h0, 16'h000A, 3'd7, 3'b010),
          1, 0, 3'd0, 16'h0, w);

    // immediate extension variants
    issue(rr(OP_SLBI, 3'd1, 3'b100, 5'b00000),
          mk(16'h0, 16'h0, 16'h0080, 3'd1, 3'b010),
          1, 0, 3'd0, 16'h0, w);
    issue(rr(OP_BEQZ, 3'd5, 3'b100, 5'b00000),
          mk(16'hBEEF, 16'h0, 16'hFF80, 3'd4, 3'b000),
          1, 0, 3'd0, 16'h0, w);
    issue(rr(OP_J, 3'b100, 3'd0, 5'b00000),
          mk(16'h0, 16'h0, 16'hFC00, 3'd0, 3'b000),
          1, 0, 3'd0, 16'h0, w);

    // illegal then HALT
    issue(rr(5'b11111, 3'd0, 3'd0, 5'b00000),
          mk(16'h0, 16'h0, 16'h0, 3'd0, 3'b001),
          1, 0, 3'd0, 16'h0, w);
    chk("err_set", {31'h0, err}, 1);
    chk("halt_not_yet", {31'h0, halt}, 0);
    issue(rr(OP_HALT, 3'd0, 3'd0, 5'b00000),
          mk(16'h0, 16'h0, 16'h0, 3'd0, 3'b000),
          1, 0, 3'd0, 16'h0, w);
    chk("halt_set", {31'h0, halt}, 1);
    in_valid = 1'b1;
    instr = rr(OP_ALU, 3'd3, 3'd0, 5'b00100);
    repeat (3) begin
      @(negedge clk);
      chk("halt_in_ready", {31'h0, in_ready}, 0);
    end
    in_valid = 1'b0;
    chk("sb_empty_halt", q.size(), 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("rst2_halt", {31'h0, halt}, 0);
    chk("rst2_err", {31'h0, err}, 0);
    chk("rst2_valid", {31'h0, out_valid}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel2_in_ready", {31'h0, in_ready}, 1);

    // register file must be cleared by reset
    issue(rr(OP_ALU, 3'd3, 3'd5, 5'b00100),
          mk(16'h0, 16'h0, 16'h0004, 3'd1, 3'b010),
          1, 0, 3'd0, 16'h0, w);
    repeat (3) @(negedge clk);
    chk("sb_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
